// File: rtl/pb_size_detector.sv
// Counts bits of one PB on a valid/ready/last stream and classifies its length.
// Optional idle watchdog aborts partial PBs when PB_TIMEOUT_EN is defined.
module pb_size_detector #(
   parameter int BEAT_BITS   = 1,
   parameter int CNT_W       = 13,
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic             in_last,
   output logic             in_ready,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [1:0]       pb_size,
   output logic [CNT_W-1:0] len_l,
   output logic             len_err,
   output logic             timeout
);

   typedef enum logic {COUNT, RESULT} state_t;

   localparam logic [CNT_W:0] MAX = {1'b0, {CNT_W{1'b1}}};

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] fin;
   logic [CNT_W:0]   sum;
   logic             accept;
   logic             sat;
   logic [1:0]       size;

   assign accept = in_valid & in_ready;
   assign sum    = {1'b0, cnt} + (CNT_W+1)'(BEAT_BITS);
   assign sat    = (sum >= MAX);
   assign fin    = sat ? MAX[CNT_W-1:0] : sum[CNT_W-1:0];

   // A saturated count can never match a legal length, so it lands on 3.
   always_comb begin
      size = 2'd3;
      if (!sat) begin
         if (32'(fin) == 32'd64)        size = 2'd0;
         else if (32'(fin) == 32'd544)  size = 2'd1;
         else if (32'(fin) == 32'd2080) size = 2'd2;
      end
   end

`ifdef PB_TIMEOUT_EN
   localparam int IW = $clog2(TIMEOUT_CYC + 1);
   logic [IW-1:0] idle;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= COUNT;
         cnt       <= '0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         pb_size   <= 2'd3;
         len_l     <= '0;
         len_err   <= 1'b0;
         timeout   <= 1'b0;
`ifdef PB_TIMEOUT_EN
         idle      <= '0;
`endif
      end else begin
         unique case (state)
            COUNT: begin
               if (accept) begin
`ifdef PB_TIMEOUT_EN
                  idle <= '0;
`endif
                  if (in_last) begin
                     len_l     <= fin;
                     pb_size   <= size;
                     len_err   <= (size == 2'd3);
                     timeout   <= 1'b0;
                     cnt       <= '0;
                     state     <= RESULT;
                     in_ready  <= 1'b0;
                     out_valid <= 1'b1;
                  end else begin
                     cnt <= fin;
                  end
               end
`ifdef PB_TIMEOUT_EN
               else if (cnt != '0) begin
                  if (idle == IW'(TIMEOUT_CYC - 1)) begin
                     idle      <= '0;
                     len_l     <= cnt;
                     pb_size   <= 2'd3;
                     len_err   <= 1'b1;
                     timeout   <= 1'b1;
                     cnt       <= '0;
                     state     <= RESULT;
                     in_ready  <= 1'b0;
                     out_valid <= 1'b1;
                  end else begin
                     idle <= idle + 1'b1;
                  end
               end
`endif
            end
            RESULT: begin
               if (out_ready) begin
                  state     <= COUNT;
                  in_ready  <= 1'b1;
                  out_valid <= 1'b0;
               end
            end
            default: state <= COUNT;
         endcase
      end
   end

endmodule

// File: tb/tb_pb_size_detector.sv
// Directed bench for pb_size_detector: length table plus stall, reset,
// saturation (CNT_W=8 twin) and idle-watchdog sequences.
module tb_pb_size_detector;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_last;
   logic        out_ready;
   logic        in_ready;
   logic        out_valid;
   logic [1:0]  pb_size;
   logic [12:0] len_l;
   logic        len_err;
   logic        timeout;
   logic        in_ready8;
   logic        out_valid8;
   logic [1:0]  pb_size8;
   logic [7:0]  len_l8;
   logic        len_err8;
   logic        timeout8;

   int total = 0;
   int pass  = 0;

   pb_size_detector #(.BEAT_BITS(1), .CNT_W(13), .TIMEOUT_CYC(16)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_last(in_last),
      .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
      .pb_size(pb_size), .len_l(len_l), .len_err(len_err), .timeout(timeout)
   );

   pb_size_detector #(.BEAT_BITS(1), .CNT_W(8), .TIMEOUT_CYC(16)) dut8 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_last(in_last),
      .in_ready(in_ready8), .out_valid(out_valid8), .out_ready(out_ready),
      .pb_size(pb_size8), .len_l(len_l8), .len_err(len_err8), .timeout(timeout8)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         beats;
      bit         gaps;
      logic [1:0] size;
      int         len;
      bit         err;
   } vec_t;

   vec_t tbl[8];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act === exp) pass++;
      else $display("FAIL %s: got %0d want %0d", name, act, exp);
   endtask

   task automatic send_pb(input int n, input bit gaps, input bit last);
      for (int i = 0; i < n; i++) begin
         if (gaps && $urandom_range(0, 1) == 1) begin
            in_valid = 1'b0;
            in_last  = 1'b1;
            step();
         end
         in_valid = 1'b1;
         in_last  = last && (i == n - 1);
         step();
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic check_res(input string name, input logic [1:0] sz,
                            input int len, input bit err, input bit to);
      chk({name, ".valid"}, 32'(out_valid), 32'd1);
      chk({name, ".ready"}, 32'(in_ready), 32'd0);
      chk({name, ".size"}, 32'(pb_size), 32'(sz));
      chk({name, ".len"}, 32'(len_l), 32'(len));
      chk({name, ".err"}, 32'(len_err), 32'(err));
      chk({name, ".tmo"}, 32'(timeout), 32'(to));
   endtask

   task automatic handshake(input string name, input logic [1:0] sz);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk({name, ".drop"}, 32'(out_valid), 32'd0);
      chk({name, ".rdy"}, 32'(in_ready), 32'd1);
      chk({name, ".hold"}, 32'(pb_size), 32'(sz));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0] = '{64,   1'b0, 2'd0, 64,   1'b0};
      tbl[1] = '{545,  1'b0, 2'd3, 545,  1'b1};
      tbl[2] = '{544,  1'b0, 2'd1, 544,  1'b0};
      tbl[3] = '{2080, 1'b1, 2'd2, 2080, 1'b0};
      tbl[4] = '{1,    1'b0, 2'd3, 1,    1'b1};
      tbl[5] = '{63,   1'b1, 2'd3, 63,   1'b1};
      tbl[6] = '{2081, 1'b0, 2'd3, 2081, 1'b1};
      tbl[7] = '{136,  1'b1, 2'd3, 136,  1'b1};

      rst       = 1'b1;
      in_valid  = 1'b0;
      in_last   = 1'b0;
      out_ready = 1'b0;
      step();
      step();
      rst = 1'b0;
      chk("rst.ready", 32'(in_ready), 32'd1);
      chk("rst.valid", 32'(out_valid), 32'd0);
      chk("rst.size", 32'(pb_size), 32'd3);
      chk("rst.len", 32'(len_l), 32'd0);
      chk("rst.err", 32'(len_err), 32'd0);
      chk("rst.tmo", 32'(timeout), 32'd0);

      in_last = 1'b1;
      step();
      step();
      in_last = 1'b0;
      chk("lastnv.valid", 32'(out_valid), 32'd0);

      for (int v = 0; v < 8; v++) begin
         send_pb(tbl[v].beats, tbl[v].gaps, 1'b1);
         check_res($sformatf("tbl%0d", v), tbl[v].size, tbl[v].len,
                   tbl[v].err, 1'b0);
         handshake($sformatf("tbl%0d", v), tbl[v].size);
      end

      send_pb(2080, 1'b1, 1'b1);
      in_valid = 1'b1;
      for (int c = 0; c < 5; c++) begin
         check_res($sformatf("stall%0d", c), 2'd2, 2080, 1'b0, 1'b0);
         step();
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk("stall.drop", 32'(out_valid), 32'd0);
      step();
      send_pb(63, 1'b0, 1'b1);
      check_res("stalled_beat", 2'd0, 64, 1'b0, 1'b0);
      handshake("stalled_beat", 2'd0);

      send_pb(300, 1'b0, 1'b1);
      check_res("sat13", 2'd3, 300, 1'b1, 1'b0);
      chk("sat8.valid", 32'(out_valid8), 32'd1);
      chk("sat8.size", 32'(pb_size8), 32'd3);
      chk("sat8.len", 32'(len_l8), 32'd255);
      chk("sat8.err", 32'(len_err8), 32'd1);
      handshake("sat", 2'd3);

      send_pb(100, 1'b0, 1'b0);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("midrst.ready", 32'(in_ready), 32'd1);
      chk("midrst.size", 32'(pb_size), 32'd3);
      chk("midrst.len", 32'(len_l), 32'd0);
      send_pb(64, 1'b0, 1'b1);
      check_res("midrst.pb", 2'd0, 64, 1'b0, 1'b0);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("resrst.valid", 32'(out_valid), 32'd0);
      chk("resrst.ready", 32'(in_ready), 32'd1);
      chk("resrst.size", 32'(pb_size), 32'd3);
      chk("resrst.len", 32'(len_l), 32'd0);

      send_pb(10, 1'b0, 1'b0);
`ifdef PB_TIMEOUT_EN
      for (int c = 0; c < 15; c++) step();
      chk("tmo.early", 32'(out_valid), 32'd0);
      step();
      check_res("tmo", 2'd3, 10, 1'b1, 1'b1);
      handshake("tmo", 2'd3);
      chk("tmo.hold", 32'(timeout), 32'd1);
      send_pb(64, 1'b0, 1'b1);
      check_res("tmo.next", 2'd0, 64, 1'b0, 1'b0);
      handshake("tmo.next", 2'd0);
`else
      for (int c = 0; c < 40; c++) step();
      chk("notmo.valid", 32'(out_valid), 32'd0);
      chk("notmo.ready", 32'(in_ready), 32'd1);
      chk("notmo.tmo", 32'(timeout), 32'd0);
      send_pb(54, 1'b0, 1'b1);
      check_res("notmo.pb", 2'd0, 64, 1'b0, 1'b0);
      handshake("notmo.pb", 2'd0);
`endif

      $display("%0d/%0d checks passed", pass, total);
      $finish;
   end

endmodule
